hazard_stall_unit: RTL and testbench

- Pipeline interlock controller for the 32-bit 5-stage MIPS core; the producer side of the stall/flush contract that the forwarding path relies on.
- Detects hazards forwarding cannot cover: load-use, branch operand dependence with ID-stage branch resolution, and data-memory wait.
- Drives PC/pipeline-register write enables and bubble-insert flushes.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/hazard_stall_unit_if.sv | 41 ++++
 rtl/hazard_stall_unit.sv | 57 +++++
 tb/tb_hazard_stall_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: pipeline-to-interlock signal bundle.
//   master (pipeline): drives ID/EX/MEM hazard sources, receives enables/flushes/status.
//   slave (hazard_stall_unit): the reverse.
//   ID_rs/ID_rt/ID_uses_rt/ID_branch/ID_redirect : ID-stage instruction info
//   EX_MemRead/EX_RegWrite/EX_WriteRegister      : EX-stage producer info
//   MEM_MemAccess/dmem_ready                     : data-memory handshake
//   *_Write/*_Flush                              : pipeline control
//   stall_count/mem_timeout                      : status
interface hazard_stall_unit_if #(parameter int CNT_W = 16);
   logic [4:0] ID_rs;
   logic [4:0] ID_rt;
   logic ID_uses_rt;
   logic ID_branch;
   logic ID_redirect;
   logic EX_MemRead;
   logic EX_RegWrite;
   logic [4:0] EX_WriteRegister;
   logic MEM_MemAccess;
   logic dmem_ready;
   logic PC_Write;
   logic IFID_Write;
   logic IFID_Flush;
   logic IDEX_Write;
   logic IDEX_Flush;
   logic EXMEM_Write;
   logic MEMWB_Flush;
   logic [CNT_W-1:0] stall_count;
   logic mem_timeout;
   modport master (
      output ID_rs, ID_rt, ID_uses_rt, ID_branch, ID_redirect,
      output EX_MemRead, EX_RegWrite, EX_WriteRegister, MEM_MemAccess, dmem_ready,
      input PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, MEMWB_Flush,
      input stall_count, mem_timeout
   );
   modport slave (
      input ID_rs, ID_rt, ID_uses_rt, ID_branch, ID_redirect,
      input EX_MemRead, EX_RegWrite, EX_WriteRegister, MEM_MemAccess, dmem_ready,
      output PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, MEMWB_Flush,
      output stall_count, mem_timeout
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: MIPS 5-stage interlock (load-use, ID-branch dependence, dmem wait).
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   hz    : hazard_stall_unit_if.slave (hazard sources in, enables/flushes/status out)
module hazard_stall_unit #(
   parameter int CNT_W = 16,
   parameter int MAX_WAIT = 64
) (
   input logic clk,
   input logic reset,
   hazard_stall_unit_if.slave hz
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   typedef enum logic [1:0] {RUN, MEM_WAIT, BR_LOAD2} state_t;
   state_t state;
   logic brPending;
   logic [WW-1:0] waitCnt;
   logic dep, loadUse, brAlu, freeze, bubble, hold;
   assign dep = hz.EX_WriteRegister != 5'd0 &&
                (hz.EX_WriteRegister == hz.ID_rs || (hz.ID_uses_rt && hz.EX_WriteRegister == hz.ID_rt));
   assign loadUse = hz.EX_MemRead && dep;
   assign brAlu = hz.ID_branch && hz.EX_RegWrite && !hz.EX_MemRead && dep;
   // Once waiting, only dmem_ready ends the freeze.
   assign freeze = !hz.dmem_ready && (state == MEM_WAIT || hz.MEM_MemAccess);
   // The release cycle of MEM_WAIT evaluates like RUN, so only BR_LOAD2 forces a bubble.
   assign bubble = state == BR_LOAD2 || loadUse || brAlu;
   assign hold = !reset || freeze;
   assign hz.PC_Write = !hold && !bubble;
   assign hz.IFID_Write = !hold && !bubble;
   assign hz.IDEX_Write = !hold;
   assign hz.EXMEM_Write = !hold;
   assign hz.MEMWB_Flush = hold;
   assign hz.IDEX_Flush = !reset || (!freeze && bubble);
   assign hz.IFID_Flush = !reset || (!freeze && !bubble && hz.ID_redirect);
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= RUN;
         brPending <= 1'b0;
         waitCnt <= '0;
         hz.mem_timeout <= 1'b0;
         hz.stall_count <= '0;
      end else begin
         if (!hz.PC_Write && hz.stall_count != '1) hz.stall_count <= hz.stall_count + 1'b1;
         if (freeze) begin
            state <= MEM_WAIT;
            // A wait that interrupts BR_LOAD2 owes that bubble once the wait ends.
            brPending <= state == BR_LOAD2 || (state == MEM_WAIT && brPending);
            if (waitCnt != WW'(MAX_WAIT)) waitCnt <= waitCnt + 1'b1;
            if (waitCnt >= WW'(MAX_WAIT - 1)) hz.mem_timeout <= 1'b1;
         end else begin
            waitCnt <= '0;
            brPending <= 1'b0;
            state <= (state != BR_LOAD2 && ((loadUse && hz.ID_branch) || brPending)) ? BR_LOAD2 : RUN;
         end
      end
   end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: vector table, directed corner sequences and random stimulus vs a reference model.
module tb_hazard_stall_unit;
   localparam int CW = 4;
   localparam int MW = 4;
   localparam int CMAX = (1 << CW) - 1;
   // {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, MEMWB_Flush}
   localparam logic [6:0] DEF = 7'b1101010;
   localparam logic [6:0] BUB = 7'b0001110;
   localparam logic [6:0] FRZ = 7'b0000001;
   localparam logic [6:0] RDR = 7'b1111010;
   localparam logic [6:0] RST = 7'b0010101;
   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic usesRt;
      logic branch;
      logic redirect;
      logic memRead;
      logic regWrite;
      logic [4:0] wr;
      logic memAcc;
      logic ready;
   } inVec_t;
   typedef struct {
      inVec_t v;
      logic [6:0] exp;
      string name;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   hazard_stall_unit_if #(.CNT_W(CW)) hif();
   hazard_stall_unit #(.CNT_W(CW), .MAX_WAIT(MW)) dut (.clk(clk), .reset(reset), .hz(hif));
   int errors = 0;
   int checks = 0;
   // Reference model: an owed branch bubble, whether the previous cycle was frozen, wait length, counters.
   bit mInWait, mOwed, mTo;
   int mWait, mStalls;
   logic [6:0] lastOut;
   logic [31:0] lastCnt;
   logic lastTo;
   vec_t tbl[$];
   function automatic inVec_t mk(int rs, int rt, bit ut, bit br, bit rd, bit mr, bit rw, int wr, bit ma, bit rdy);
      inVec_t v;
      v.rs = 5'(rs);
      v.rt = 5'(rt);
      v.usesRt = ut;
      v.branch = br;
      v.redirect = rd;
      v.memRead = mr;
      v.regWrite = rw;
      v.wr = 5'(wr);
      v.memAcc = ma;
      v.ready = rdy;
      return v;
   endfunction
   function automatic vec_t tv(inVec_t v, logic [6:0] e, string n);
      vec_t t;
      t.v = v;
      t.exp = e;
      t.name = n;
      return t;
   endfunction
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   task automatic step(input inVec_t v, input logic rstN, input string name);
      logic [6:0] e;
      logic [31:0] eCnt;
      logic eTo;
      bit dep, lu, bra, frozen;
      @(negedge clk);
      reset = rstN;
      hif.ID_rs = v.rs;
      hif.ID_rt = v.rt;
      hif.ID_uses_rt = v.usesRt;
      hif.ID_branch = v.branch;
      hif.ID_redirect = v.redirect;
      hif.EX_MemRead = v.memRead;
      hif.EX_RegWrite = v.regWrite;
      hif.EX_WriteRegister = v.wr;
      hif.MEM_MemAccess = v.memAcc;
      hif.dmem_ready = v.ready;
      #2;
      eCnt = 32'(mStalls);
      eTo = mTo;
      if (!rstN) begin
         e = RST;
         mInWait = 0;
         mOwed = 0;
         mTo = 0;
         mWait = 0;
         mStalls = 0;
      end else begin
         dep = v.wr != 0 && (v.wr == v.rs || (v.usesRt && v.wr == v.rt));
         lu = v.memRead && dep;
         bra = v.branch && v.regWrite && !v.memRead && dep;
         frozen = !v.ready && (mInWait || v.memAcc);
         if (frozen) e = FRZ;
         else if (mOwed && !mInWait) begin
            e = BUB;
            mOwed = 0;
         end else if (lu || bra) begin
            e = BUB;
            if (lu && v.branch) mOwed = 1;
         end else if (v.redirect) e = RDR;
         else e = DEF;
         if (frozen) begin
            mWait++;
            if (mWait >= MW) mTo = 1;
         end else mWait = 0;
         mInWait = frozen;
         if (!e[6] && mStalls < CMAX) mStalls++;
      end
      lastOut = {hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Write,
                 hif.IDEX_Flush, hif.EXMEM_Write, hif.MEMWB_Flush};
      lastCnt = 32'(hif.stall_count);
      lastTo = hif.mem_timeout;
      check({name, " ctl"}, 32'(lastOut), 32'(e));
      check({name, " cnt"}, lastCnt, eCnt);
      check({name, " tmo"}, 32'(lastTo), 32'(eTo));
   endtask
   initial begin
      inVec_t idle, lb, mw, lu, v;
      int bias;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      lb = mk(1, 3, 1, 1, 0, 1, 1, 3, 0, 1);
      mw = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      lu = mk(2, 0, 0, 0, 0, 1, 1, 2, 0, 1);
      tbl.push_back(tv(mk(1, 2, 1, 0, 0, 1, 1, 3, 0, 1), DEF, "noDep"));
      tbl.push_back(tv(mk(2, 0, 0, 0, 0, 1, 1, 2, 0, 1), BUB, "luRs"));
      tbl.push_back(tv(mk(1, 4, 1, 0, 0, 1, 1, 4, 0, 1), BUB, "luRt"));
      tbl.push_back(tv(mk(1, 4, 0, 0, 0, 1, 1, 4, 0, 1), DEF, "rtUnused"));
      tbl.push_back(tv(mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 1), DEF, "reg0"));
      tbl.push_back(tv(mk(5, 6, 1, 1, 0, 0, 1, 5, 0, 1), BUB, "brAlu"));
      tbl.push_back(tv(mk(5, 6, 1, 0, 0, 0, 1, 5, 0, 1), DEF, "aluNoBr"));
      tbl.push_back(tv(mk(7, 5, 1, 1, 0, 0, 0, 5, 0, 1), DEF, "brNoWrite"));
      tbl.push_back(tv(mk(1, 2, 1, 0, 1, 0, 1, 3, 0, 1), RDR, "redirect"));
      tbl.push_back(tv(mk(3, 0, 0, 0, 1, 1, 1, 3, 0, 1), BUB, "redirLu"));
      tbl.push_back(tv(mk(1, 2, 1, 0, 0, 0, 0, 0, 1, 1), DEF, "memReady"));
      tbl.push_back(tv(mk(9, 9, 1, 1, 1, 0, 1, 9, 0, 1), BUB, "redirBrAlu"));
      tbl.push_back(tv(mk(0, 9, 1, 1, 0, 0, 1, 0, 0, 1), DEF, "brReg0"));
      step(idle, 1'b0, "reset");
      check("resetPattern", 32'(lastOut), 32'(RST));
      step(idle, 1'b0, "reset2");
      check("resetCnt", lastCnt, 0);
      check("resetTmo", 32'(lastTo), 0);
      foreach (tbl[i]) begin
         step(tbl[i].v, 1'b1, tbl[i].name);
         check({tbl[i].name, " tbl"}, 32'(lastOut), 32'(tbl[i].exp));
      end
      step(idle, 1'b0, "rstA");
      step(lu, 1'b1, "luStall");
      check("luStall", 32'(lastOut), 32'(BUB));
      step(idle, 1'b1, "luAfter");
      check("luAfter", 32'(lastOut), 32'(DEF));
      check("luCount", lastCnt, 1);
      step(idle, 1'b0, "rstB");
      step(lb, 1'b1, "lbFirst");
      check("lbFirst", 32'(lastOut), 32'(BUB));
      step(idle, 1'b1, "lbSecond");
      check("lbSecond", 32'(lastOut), 32'(BUB));
      step(idle, 1'b1, "lbDone");
      check("lbDone", 32'(lastOut), 32'(DEF));
      check("lbCount", lastCnt, 2);
      step(idle, 1'b0, "rstC");
      for (int i = 1; i <= 5; i++) begin
         step(mw, 1'b1, $sformatf("wait%0d", i));
         check($sformatf("wait%0d frz", i), 32'(lastOut), 32'(FRZ));
         check($sformatf("wait%0d tmo", i), 32'(lastTo), (i == 5) ? 1 : 0);
      end
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b1, "release");
      check("release", 32'(lastOut), 32'(DEF));
      check("releaseTmo", 32'(lastTo), 1);
      check("waitCount", lastCnt, 5);
      step(idle, 1'b1, "tmoHeld");
      check("tmoHeld", 32'(lastTo), 1);
      v = lu;
      v.memAcc = 1;
      v.ready = 0;
      step(v, 1'b1, "prioMem");
      check("prioMem", 32'(lastOut), 32'(FRZ));
      v.ready = 1;
      step(v, 1'b1, "prioLuAfter");
      check("prioLuAfter", 32'(lastOut), 32'(BUB));
      v = lu;
      v.redirect = 1;
      step(v, 1'b1, "redirLuSeq");
      check("redirLuNoFlush", 32'(lastOut[4]), 0);
      step(lb, 1'b1, "rbFirst");
      step(idle, 1'b0, "rbReset");
      check("rbReset", 32'(lastOut), 32'(RST));
      step(idle, 1'b0, "rbReset2");
      check("rbResetCnt", lastCnt, 0);
      check("rbResetTmo", 32'(lastTo), 0);
      step(idle, 1'b1, "rbRelease");
      check("rbRelease", 32'(lastOut), 32'(DEF));
      step(lb, 1'b1, "bwFirst");
      step(mw, 1'b1, "bwWait1");
      check("bwWait1", 32'(lastOut), 32'(FRZ));
      step(mw, 1'b1, "bwWait2");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b1, "bwRelease");
      check("bwRelease", 32'(lastOut), 32'(DEF));
      step(idle, 1'b1, "bwBubble");
      check("bwBubble", 32'(lastOut), 32'(BUB));
      step(idle, 1'b1, "bwDone");
      check("bwDone", 32'(lastOut), 32'(DEF));
      for (int i = 0; i < 3000; i++) begin
         bias = ((i / 200) % 2 != 0) ? 1 : 3;
         v.rs = 5'($urandom_range(0, 3));
         v.rt = 5'($urandom_range(0, 3));
         v.usesRt = 1'($urandom_range(0, 1));
         v.branch = 1'($urandom_range(0, 1));
         v.redirect = 1'($urandom_range(0, 1));
         v.memRead = 1'($urandom_range(0, 1));
         v.regWrite = 1'($urandom_range(0, 1));
         v.wr = 5'($urandom_range(0, 3));
         v.memAcc = 1'($urandom_range(0, 1));
         v.ready = $urandom_range(0, bias) != 0;
         step(v, $urandom_range(0, 99) != 0, "rand");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
